// File: rtl/reg_file_dual_pkg.sv
// Shared pipeline package: register-file geometry defaults and the register-address type
// used by the decode and write-back stages.
package reg_file_dual_pkg;

  localparam int unsigned RegDataWidth = 32;
  localparam int unsigned RegAddrWidth = 5;

  typedef logic [RegAddrWidth-1:0] reg_addr_t;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port of the dual-issue register file.
// Decodes the address against the stored register image, forces register 0 to read zero,
// and (with REGFILE_BYPASS_EN defined) forwards same-cycle write data from lane A or B,
// lane B taking precedence. Bypass is suppressed while reset is high.
//
// Ports:
//   reset_i          synchronous reset of the parent; gates bypass only
//   rf_i             stored register contents, one DW-bit word per register
//   addr_i           read address
//   we_a_i/wa_a_i/wd_a_i  lane A (older) write enable / address / data
//   we_b_i/wa_b_i/wd_b_i  lane B (younger) write enable / address / data
//   rd_o             read data
//
// Config macro: REGFILE_BYPASS_EN (undefined: stored contents only).
module reg_read_port
  import reg_file_dual_pkg::*;
#(
  parameter int unsigned DW = RegDataWidth,
  parameter int unsigned AW = RegAddrWidth
) (
  input  logic                     reset_i,
  input  logic [2**AW-1:0][DW-1:0] rf_i,
  input  logic [AW-1:0]            addr_i,
  input  logic                     we_a_i,
  input  logic [AW-1:0]            wa_a_i,
  input  logic [DW-1:0]            wd_a_i,
  input  logic                     we_b_i,
  input  logic [AW-1:0]            wa_b_i,
  input  logic [DW-1:0]            wd_b_i,
  output logic [DW-1:0]            rd_o
);

  always_comb begin
    rd_o = rf_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    if (!reset_i) begin
      if (we_a_i && (wa_a_i == addr_i)) rd_o = wd_a_i;
      // Younger lane overrides the older one on a double match.
      if (we_b_i && (wa_b_i == addr_i)) rd_o = wd_b_i;
    end
`endif
    // Applied last so neither stored data nor a bypass can leak through register 0.
    if (addr_i == '0) rd_o = '0;
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{reset_i, we_a_i, wa_a_i, wd_a_i, we_b_i, wa_b_i, wd_b_i};
`endif

endmodule

// File: rtl/reg_file_dual.sv
// Dual-write, quad-read register file for a two-wide pipeline.
// Lane A is the older instruction, lane B the younger; when both write the same register
// in one cycle, lane B's data is kept. Register 0 is hardwired to zero. Reads are
// combinational through four identical reg_read_port instances.
//
// Ports:
//   clk, reset                   clock; synchronous active-high reset clearing all registers
//   RegWriteWA/WB                write enables, lane A / lane B
//   WriteRegWA/WB, ResultWA/WB   write address / data, lane A / lane B
//   RsA, RtA, RsB, RtB           read addresses
//   RdRsA, RdRtA, RdRsB, RdRtB   read data
//
// Config macro: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_file_dual
  import reg_file_dual_pkg::*;
#(
  parameter int unsigned DW = RegDataWidth,
  parameter int unsigned AW = RegAddrWidth
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RegWriteWA,
  input  logic          RegWriteWB,
  input  logic [AW-1:0] WriteRegWA,
  input  logic [AW-1:0] WriteRegWB,
  input  logic [DW-1:0] ResultWA,
  input  logic [DW-1:0] ResultWB,
  input  logic [AW-1:0] RsA,
  input  logic [AW-1:0] RtA,
  input  logic [AW-1:0] RsB,
  input  logic [AW-1:0] RtB,
  output logic [DW-1:0] RdRsA,
  output logic [DW-1:0] RdRtA,
  output logic [DW-1:0] RdRsB,
  output logic [DW-1:0] RdRtB
);

  localparam int unsigned Depth = 2**AW;

  logic [Depth-1:0][DW-1:0] regs_q;
  logic                     wr_a, wr_b;

  assign wr_a = RegWriteWA && (WriteRegWA != '0);
  assign wr_b = RegWriteWB && (WriteRegWB != '0);

  // Lane B is assigned after lane A, so on a shared address its NBA lands last and wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      if (wr_a) regs_q[WriteRegWA] <= ResultWA;
      if (wr_b) regs_q[WriteRegWB] <= ResultWB;
    end
  end

  reg_read_port #(.DW(DW), .AW(AW)) u_rd_rs_a (
    .reset_i (reset),      .rf_i   (regs_q),     .addr_i (RsA),
    .we_a_i  (RegWriteWA), .wa_a_i (WriteRegWA), .wd_a_i (ResultWA),
    .we_b_i  (RegWriteWB), .wa_b_i (WriteRegWB), .wd_b_i (ResultWB),
    .rd_o    (RdRsA)
  );

  reg_read_port #(.DW(DW), .AW(AW)) u_rd_rt_a (
    .reset_i (reset),      .rf_i   (regs_q),     .addr_i (RtA),
    .we_a_i  (RegWriteWA), .wa_a_i (WriteRegWA), .wd_a_i (ResultWA),
    .we_b_i  (RegWriteWB), .wa_b_i (WriteRegWB), .wd_b_i (ResultWB),
    .rd_o    (RdRtA)
  );

  reg_read_port #(.DW(DW), .AW(AW)) u_rd_rs_b (
    .reset_i (reset),      .rf_i   (regs_q),     .addr_i (RsB),
    .we_a_i  (RegWriteWA), .wa_a_i (WriteRegWA), .wd_a_i (ResultWA),
    .we_b_i  (RegWriteWB), .wa_b_i (WriteRegWB), .wd_b_i (ResultWB),
    .rd_o    (RdRsB)
  );

  reg_read_port #(.DW(DW), .AW(AW)) u_rd_rt_b (
    .reset_i (reset),      .rf_i   (regs_q),     .addr_i (RtB),
    .we_a_i  (RegWriteWA), .wa_a_i (WriteRegWA), .wd_a_i (ResultWA),
    .we_b_i  (RegWriteWB), .wa_b_i (WriteRegWB), .wd_b_i (ResultWB),
    .rd_o    (RdRtB)
  );

endmodule

// File: tb/tb_reg_file_dual.sv
// Self-checking bench for reg_file_dual: directed scenarios followed by random traffic,
// compared against an array-based reference model of the register file.
module tb_reg_file_dual;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWriteWA, RegWriteWB;
  logic [AW-1:0] WriteRegWA, WriteRegWB;
  logic [DW-1:0] ResultWA, ResultWB;
  logic [AW-1:0] RsA, RtA, RsB, RtB;
  logic [DW-1:0] RdRsA, RdRtA, RdRsB, RdRtB;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] model [32];

  reg_file_dual #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteWA (RegWriteWA),
    .RegWriteWB (RegWriteWB),
    .WriteRegWA (WriteRegWA),
    .WriteRegWB (WriteRegWB),
    .ResultWA   (ResultWA),
    .ResultWB   (ResultWB),
    .RsA        (RsA),
    .RtA        (RtA),
    .RsB        (RsB),
    .RtB        (RtB),
    .RdRsA      (RdRsA),
    .RdRtA      (RdRtA),
    .RdRsB      (RdRsB),
    .RdRtB      (RdRtB)
  );

  always #5 clk = ~clk;

  // Value a read of address a should return right now, from the model and current inputs.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!reset) begin
      if (RegWriteWB && WriteRegWB == a) return ResultWB;
      if (RegWriteWA && WriteRegWA == a) return ResultWA;
    end
`endif
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input logic wea, input logic [AW-1:0] waa, input logic [DW-1:0] wda,
                        input logic web, input logic [AW-1:0] wab, input logic [DW-1:0] wdb);
    RegWriteWA = wea; WriteRegWA = waa; ResultWA = wda;
    RegWriteWB = web; WriteRegWB = wab; ResultWB = wdb;
  endtask

  task automatic set_rd(input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] c, input logic [AW-1:0] d);
    RsA = a; RtA = b; RsB = c; RtB = d;
  endtask

  // Wait to mid-cycle and compare all four read ports against the model.
  task automatic sample(input bit do_check);
    @(negedge clk);
    if (do_check) begin
      check("RdRsA", RdRsA, exp_rd(RsA));
      check("RdRtA", RdRtA, exp_rd(RtA));
      check("RdRsB", RdRsB, exp_rd(RsB));
      check("RdRtB", RdRtB, exp_rd(RtB));
    end
  endtask

  // Advance through the rising edge and apply the architectural write rules to the model.
  task automatic commit();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else begin
      if (RegWriteWA && WriteRegWA != 0) model[WriteRegWA] = ResultWA;
      if (RegWriteWB && WriteRegWB != 0) model[WriteRegWB] = ResultWB;
    end
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b1;
    set_wr(0, 0, 0, 0, 0, 0);
    set_rd(0, 0, 0, 0);
    sample(0);
    commit();
    reset = 1'b0;

    // Dirty the file so the following reset has something to clear.
    for (int i = 0; i < 12; i++) begin
      set_wr(1, AW'($urandom_range(1, 31)), $urandom, 1, AW'($urandom_range(1, 31)), $urandom);
      set_rd(rand_addr(), rand_addr(), rand_addr(), rand_addr());
      sample(1);
      commit();
    end

    // One reset edge, then every address reads zero.
    reset = 1'b1;
    set_wr(0, 0, 0, 0, 0, 0);
    sample(1);
    commit();
    reset = 1'b0;
    for (int base = 0; base < 32; base += 4) begin
      set_rd(AW'(base), AW'(base + 1), AW'(base + 2), AW'(base + 3));
      sample(1);
      check("rst_zero_rs_a", RdRsA, '0);
      check("rst_zero_rt_b", RdRtB, '0);
      commit();
    end

    // Two lanes, two different registers.
    set_wr(1, 5, 32'h1234_5678, 1, 6, 32'hDEAD_BEEF);
    set_rd(0, 0, 0, 0);
    sample(1);
    commit();
    set_wr(0, 0, 0, 0, 0, 0);
    set_rd(5, 0, 0, 6);
    sample(1);
    check("r5_lane_a", RdRsA, 32'h1234_5678);
    check("r6_lane_b", RdRtB, 32'hDEAD_BEEF);
    commit();

    // Same register on both lanes: younger lane B wins.
    set_wr(1, 9, 32'h1, 1, 9, 32'h2);
    set_rd(9, 1, 2, 3);
    sample(1);
    commit();
    set_wr(0, 0, 0, 0, 0, 0);
    set_rd(9, 9, 9, 9);
    sample(1);
    check("r9_b_wins", RdRsA, 32'h2);
    commit();

    // Writes to r0 never stick nor bypass.
    set_wr(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF);
    set_rd(0, 0, 0, 0);
    sample(1);
    check("r0_same_cycle_a", RdRsA, '0);
    check("r0_same_cycle_b", RdRtB, '0);
    commit();
    set_wr(0, 0, 0, 0, 0, 0);
    sample(1);
    check("r0_after", RdRsB, '0);
    commit();

    // Read-during-write of r3.
    set_wr(1, 3, 32'h11, 0, 0, 0);
    sample(1);
    commit();
    set_wr(1, 3, 32'hAA, 0, 0, 0);
    set_rd(0, 0, 3, 0);
    sample(1);
`ifdef REGFILE_BYPASS_EN
    check("r3_bypass", RdRsB, 32'hAA);
`else
    check("r3_old", RdRsB, 32'h11);
`endif
    commit();
    set_wr(0, 0, 0, 0, 0, 0);
    sample(1);
    check("r3_new", RdRsB, 32'hAA);
    commit();

    // Reset beats a simultaneous write; no bypass while reset is high.
    set_wr(1, 7, 32'h55, 0, 0, 0);
    set_rd(7, 0, 0, 0);
    sample(1);
    commit();
    reset = 1'b1;
    set_wr(1, 7, 32'h66, 1, 7, 32'h77);
    sample(1);
    check("r7_during_reset", RdRsA, 32'h55);
    commit();
    reset = 1'b0;
    set_wr(0, 0, 0, 0, 0, 0);
    sample(1);
    check("r7_after_reset", RdRsA, '0);
    commit();

    // Random traffic with heavy address aliasing and occasional resets.
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 31) == 0);
      set_wr(1'($urandom), rand_addr(), $urandom, 1'($urandom), rand_addr(), $urandom);
      set_rd(rand_addr(), rand_addr(), rand_addr(), rand_addr());
      sample(1);
      commit();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_dual.md
REG_FILE_DUAL -- requirements
Module: reg_file_dual

Interface
REQ-001 SHALL have parameter: DW, 32, data width of each register.
REQ-002 SHALL have parameter: AW, 5, register address width; depth is 2**AW.
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 SHALL have ports: RegWriteWA / RegWriteWB  input  1  write enable, lane A (older) / lane B (younger), driven by the write-back stage.
REQ-006 SHALL have ports: WriteRegWA / WriteRegWB  input  AW  destination register, lane A / lane B.
REQ-007 SHALL have ports: ResultWA / ResultWB  input  DW  write data, lane A / lane B.
REQ-008 SHALL have ports: RsA, RtA, RsB, RtB  input  AW  four read addresses for the decode stage.
REQ-009 SHALL have ports: RdRsA, RdRtA, RdRsB, RdRtB  output  DW  four read data outputs, one per read address.

Function
REQ-010 SHALL hold 2**AW registers of DW bits; register 0 always reads 0 and is never written.
REQ-011 SHALL write ResultWA into WriteRegWA at rising edge when RegWriteWA=1 and WriteRegWA!=0; same rule for lane B.
REQ-012 SHALL, when both lanes write the same non-zero register in one cycle, store lane B's data (younger instruction wins); lane A's write is dropped.
REQ-013 SHALL leave all other registers unchanged in any cycle; one lane disabled does not affect the other's write.
REQ-014 SHALL provide combinational reads: each read output reflects its address in the same cycle, zero cycles of latency.
REQ-015 SHALL return 0 on any read port addressed to register 0 regardless of bypass or pending writes.
REQ-016 SHALL keep the four read ports fully independent; any port may alias any other or any write address.
REQ-017 SHALL give write enables priority over nothing else: there are no stall or flush inputs, and a write presented is always committed.

Reset
REQ-018 SHALL clear every register to 0 on a rising edge with reset=1; writes presented in that cycle are discarded.
REQ-019 SHALL resume normal writes on the first rising edge with reset=0; reads during reset show the pre-edge contents, except bypass, which SHALL be suppressed while reset=1.
REQ-020 SHALL produce 0 on all read outputs after reset until a register is written.

Configuration
REQ-021 SHALL support macro REGFILE_BYPASS_EN. When defined, a read whose address matches a same-cycle enabled, non-zero write returns the write data; if both lanes match, it returns lane B's data. When undefined, reads return stored (pre-edge) contents only, and the hazard unit covers the extra cycle.

Structure
REQ-022 SHALL place DW/AW defaults and the register-address typedef in the shared pipeline package used by the decode and write-back stages.
REQ-023 SHALL implement each read port as one instance of sub-module reg_read_port, which performs the address decode, the zero-register override and the bypass selection. The four instances are identical.

Verification
REQ-024 SHALL cover: reset=1 for one edge, then read all 32 addresses -> all outputs 0.
REQ-025 SHALL cover: A writes r5=0x1234_5678 and B writes r6=0xDEAD_BEEF in one cycle; next cycle RsA=5, RtB=6 -> 0x1234_5678 and 0xDEAD_BEEF.
REQ-026 SHALL cover: A and B both write r9 (A=0x1, B=0x2) -> r9 reads 0x2 afterwards.
REQ-027 SHALL cover: write r0=0xFFFF_FFFF on both lanes -> all r0 reads return 0, with and without bypass.
REQ-028 SHALL cover: with REGFILE_BYPASS_EN, write r3=0xAA while RsB=3 in the same cycle -> RdRsB=0xAA in that cycle. Without the macro, RdRsB shows the old r3 value, then 0xAA the next cycle.
REQ-029 SHALL cover: r7=0x55 stored, then reset=1 with a simultaneous write r7=0x66 -> r7 reads 0 after the edge.
